// File: rtl/mc10_bus_ctrl.sv
// MC-10 CPU bus controller: E-clock cycle decode, RAM req/ack with hold-off
// and timeout, ROM/keyboard/open-bus read mux, and write-only control latches.
module mc10_bus_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MEM_AW   = 21,
  parameter int unsigned EXT_RAM  = 1,
  parameter int unsigned NUM_CTRL = 2,
  parameter int unsigned CTRL_RST = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         e_clk,
  input  logic [15:0]                  cpu_addr,
  input  logic                         cpu_rw,
  input  logic [DATA_W-1:0]            cpu_dout,
  output logic [DATA_W-1:0]            cpu_din,
  output logic                         cpu_hold,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [MEM_AW-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            rom_data,
  input  logic [DATA_W-1:0]            kbd_data,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_q,
  output logic                         bus_err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [1:0] {REG_OPEN, REG_ROM, REG_RAM, REG_IO} region_t;

  // Address decode, highest priority first
  function automatic region_t f_decode(input logic [15:0] a);
    if (a[15:14] == 2'b11)
      return REG_ROM;
    else if ((a[15:14] == 2'b01) || ((EXT_RAM != 0) && (a[15:12] == 4'b1000)))
      return REG_RAM;
    else if ((a[15:14] == 2'b10) && (a[13:12] != 2'b00))
      return REG_IO;
    else
      return REG_OPEN;
  endfunction

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic                             r_e_d;
  logic [15:0]                      r_addr;
  logic                             r_rw;
  logic [CNT_W-1:0]                 r_cnt;
  logic [DATA_W-1:0]                r_rd_q;
  logic                             r_bus_err;
  logic [MEM_AW-1:0]                r_mem_addr;
  logic [DATA_W-1:0]                r_mem_wdata;
  logic [NUM_CTRL-1:0][DATA_W-1:0]  r_ctrl;

  logic                             w_start;
  logic                             w_ram_start;
  logic                             w_io_wr;
  region_t                          w_reg_live;
  region_t                          w_reg_q;
  logic [CNT_W-1:0]                 w_cnt_inc;
  logic                             w_tmo;
  logic                             w_rd_load;
  logic                             w_err_set;
  logic [IDX_W-1:0]                 w_idx;

  // A start is accepted only from IDLE; under hold no new E cycle can begin
  assign w_start     = e_clk & ~r_e_d & (r_state == S_IDLE);
  assign w_reg_live  = f_decode(cpu_addr);
  assign w_reg_q     = f_decode(r_addr);
  assign w_ram_start = w_start & (w_reg_live == REG_RAM);
  assign w_io_wr     = w_start & ~cpu_rw & (w_reg_live == REG_IO);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_tmo       = (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_idx       = (NUM_CTRL > 1) ? cpu_addr[IDX_W-1:0] : '0;

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ctrl_q    = r_ctrl;
  assign bus_err   = r_bus_err;

  // FSM state register
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state; ack wins over a coincident timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_ram_start)        w_state_nxt = S_REQ;
      S_REQ:   if (mem_ack || w_tmo)   w_state_nxt = S_DONE;
      S_DONE:  if (!e_clk)             w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request/hold are decoded from the state register
  always_comb begin
    mem_req   = 1'b0;
    cpu_hold  = 1'b0;
    mem_we    = 1'b0;
    w_rd_load = 1'b0;
    w_err_set = 1'b0;
    if (r_state == S_REQ) begin
      mem_req  = 1'b1;
      cpu_hold = 1'b1;
      mem_we   = ~r_rw;
      if (mem_ack)    w_rd_load = r_rw;
      else if (w_tmo) w_err_set = 1'b1;
    end
  end

  // Cycle capture, RAM datapath, timeout counter and sticky error
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_e_d       <= 1'b0;
      r_addr      <= '0;
      r_rw        <= 1'b1;
      r_cnt       <= '0;
      r_rd_q      <= '0;
      r_bus_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_e_d <= e_clk;
      if (w_start) begin
        r_addr <= cpu_addr;
        r_rw   <= cpu_rw;
      end
      if (w_ram_start) begin
        r_mem_addr  <= MEM_AW'({~cpu_addr[14], cpu_addr[13:0]});
        r_mem_wdata <= cpu_dout;
        r_cnt       <= '0;
      end else if (r_state == S_REQ) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_rd_load)      r_rd_q <= mem_rdata;
      else if (w_err_set) r_rd_q <= '1;
      if (w_err_set) r_bus_err <= 1'b1;
    end
  end

  // Write-only control latches, loaded at cycle start
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_ctrl <= {NUM_CTRL{DATA_W'(CTRL_RST)}};
    end else if (w_io_wr) begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        if (w_idx == IDX_W'(i)) r_ctrl[i] <= cpu_dout;
      end
    end
  end

  // CPU read mux from the captured address
  always_comb begin
    cpu_din = '0;
    unique case (w_reg_q)
      REG_ROM: cpu_din = rom_data;
      REG_IO:  cpu_din = kbd_data;
      REG_RAM: cpu_din = r_rd_q;
      default: cpu_din = DATA_W'(r_addr[7:0]);
    endcase
  end

endmodule

// File: tb/tb_mc10_bus_ctrl.sv
// Scoreboard bench for mc10_bus_ctrl: stimulus queues expected memory
// requests, hold lengths and read data; monitors pop and compare.
module tb_mc10_bus_ctrl;

  logic        clk;
  logic        RST;
  logic        e_clk;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  rom_data;
  logic [7:0]  kbd_data;

  logic [7:0]  cpu_din;
  logic        cpu_hold;
  logic        mem_req;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] ctrl_q;
  logic        bus_err;

  logic [7:0]  u0_cpu_din;
  logic        u0_cpu_hold;
  logic        u0_mem_req;
  logic        u0_mem_we;
  logic [20:0] u0_mem_addr;
  logic [7:0]  u0_mem_wdata;
  logic [15:0] u0_ctrl_q;
  logic        u0_bus_err;

  mc10_bus_ctrl #(
    .DATA_W(8), .MEM_AW(21), .EXT_RAM(1), .NUM_CTRL(2), .CTRL_RST(5), .TIMEOUT(4)
  ) u_dut (
    .clk(clk), .RST(RST), .e_clk(e_clk), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_hold(cpu_hold), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rom_data(rom_data), .kbd_data(kbd_data), .ctrl_q(ctrl_q),
    .bus_err(bus_err)
  );

  mc10_bus_ctrl #(
    .DATA_W(8), .MEM_AW(21), .EXT_RAM(0), .NUM_CTRL(2), .CTRL_RST(5), .TIMEOUT(4)
  ) u_dut0 (
    .clk(clk), .RST(RST), .e_clk(e_clk), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout), .cpu_din(u0_cpu_din), .cpu_hold(u0_cpu_hold),
    .mem_req(u0_mem_req), .mem_we(u0_mem_we), .mem_addr(u0_mem_addr),
    .mem_wdata(u0_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rom_data(rom_data), .kbd_data(kbd_data), .ctrl_q(u0_ctrl_q), .bus_err(u0_bus_err)
  );

  typedef struct {
    logic [20:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } mem_exp_t;

  typedef struct {
    bit         chk;
    logic [7:0] v;
  } din_exp_t;

  mem_exp_t q_mem[$];
  int       q_hold[$];
  din_exp_t q_din[$];

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   prev_req = 0;
  int   hold_cnt = 0;
  logic [7:0] last_din = '0;
  bit   u0_watch = 0;
  bit   u0_req_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory-request and hold-length monitor
  always @(negedge clk) begin
    if (mon_en) begin
      last_din = cpu_din;
      if (mem_req && !prev_req) begin
        if (q_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req_unexpected: got addr %0h expected no request", mem_addr);
        end else begin
          mem_exp_t e;
          e = q_mem.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end
      prev_req = mem_req;
      if (cpu_hold) begin
        hold_cnt++;
      end else if (hold_cnt > 0) begin
        if (q_hold.size() == 0) begin
          checks++; errors++;
          $display("FAIL hold_unexpected: got %0d clks expected none", hold_cnt);
        end else begin
          check("hold_len", 32'(hold_cnt), 32'(q_hold.pop_front()));
        end
        hold_cnt = 0;
      end
      if (u0_watch && u0_mem_req) u0_req_seen = 1;
    end
  end

  // Read-data monitor: value presented just before the E clock falls
  always @(negedge e_clk) begin
    if (mon_en) begin
      if (q_din.size() == 0) begin
        checks++; errors++;
        $display("FAIL din_unexpected: got cycle end expected none");
      end else begin
        din_exp_t d;
        d = q_din.pop_front();
        if (d.chk) check("cpu_din", 32'(last_din), 32'(d.v));
      end
    end
  end

  // One E-clock bus cycle; ack_at = REQ cycle index carrying mem_ack (0 = none)
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           input int ack_at, input logic [7:0] rd, input int n_hi);
    @(posedge clk); #1;
    cpu_addr = a; cpu_rw = rw; cpu_dout = d; e_clk = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= n_hi; k++) begin
      mem_ack   = (k == ack_at);
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    e_clk = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    RST = 1'b0; e_clk = 1'b0; cpu_addr = '0; cpu_rw = 1'b1; cpu_dout = '0;
    mem_rdata = '0; mem_ack = 1'b0; rom_data = '0; kbd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_ctrl_q", 32'(ctrl_q), 32'h0505);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_cpu_din", 32'(cpu_din), 0);
    @(negedge clk); RST = 1'b1; mon_en = 1;
    repeat (2) @(posedge clk);
    #1;

    // ROM read, then a stray ack while idle
    rom_data = 8'h7E;
    q_din.push_back('{1'b1, 8'h7E});
    bus_cycle(16'hE000, 1'b1, 8'h00, 0, 8'h00, 3);
    mem_ack = 1'b1; @(posedge clk); #1; mem_ack = 1'b0;
    @(posedge clk); #1;
    check("idle_ack_req", 32'(mem_req), 0);
    check("idle_ack_hold", 32'(cpu_hold), 0);
    check("idle_ack_din", 32'(cpu_din), 32'h7E);

    // RAM read, ack in third REQ cycle
    q_mem.push_back('{21'h00123, 1'b0, 8'h00});
    q_hold.push_back(3);
    q_din.push_back('{1'b1, 8'h5A});
    bus_cycle(16'h4123, 1'b1, 8'h00, 3, 8'h5A, 6);

    // Ack on the very cycle the timeout is reached counts as success
    q_mem.push_back('{21'h01000, 1'b0, 8'h00});
    q_hold.push_back(4);
    q_din.push_back('{1'b1, 8'h3C});
    bus_cycle(16'h5000, 1'b1, 8'h00, 4, 8'h3C, 6);
    check("edge_ack_bus_err", 32'(bus_err), 0);

    // Extended RAM write and read; the EXT_RAM=0 copy sees open bus
    u0_watch = 1; u0_req_seen = 0;
    q_mem.push_back('{21'h04010, 1'b1, 8'hC3});
    q_hold.push_back(1);
    q_din.push_back('{1'b0, 8'h00});
    bus_cycle(16'h8010, 1'b0, 8'hC3, 1, 8'h00, 4);
    q_mem.push_back('{21'h04010, 1'b0, 8'h00});
    q_hold.push_back(2);
    q_din.push_back('{1'b1, 8'h99});
    bus_cycle(16'h8010, 1'b1, 8'h00, 2, 8'h99, 4);
    u0_watch = 0;
    check("noext_mem_req", 32'(u0_req_seen), 0);
    check("noext_cpu_din", 32'(u0_cpu_din), 32'h10);

    // Control latch writes, then keyboard read
    q_din.push_back('{1'b0, 8'h00});
    bus_cycle(16'hBFFF, 1'b0, 8'h28, 0, 8'h00, 2);
    check("ctrl_after_bfff", 32'(ctrl_q), 32'h2805);
    q_din.push_back('{1'b0, 8'h00});
    bus_cycle(16'hBFFE, 1'b0, 8'h81, 0, 8'h00, 2);
    check("ctrl_after_bffe", 32'(ctrl_q), 32'h2881);
    kbd_data = 8'h3C;
    q_din.push_back('{1'b1, 8'h3C});
    bus_cycle(16'hBFFF, 1'b1, 8'h00, 0, 8'h00, 3);
    check("ctrl_after_io_rd", 32'(ctrl_q), 32'h2881);

    // Open bus read returns the low address byte
    q_din.push_back('{1'b1, 8'h55});
    bus_cycle(16'h0055, 1'b1, 8'h00, 0, 8'h00, 3);

    // Timeout, then a good cycle with bus_err staying set
    q_mem.push_back('{21'h00200, 1'b0, 8'h00});
    q_hold.push_back(4);
    q_din.push_back('{1'b1, 8'hFF});
    bus_cycle(16'h4200, 1'b1, 8'h00, 0, 8'h00, 6);
    check("tmo_bus_err", 32'(bus_err), 1);
    q_mem.push_back('{21'h03FFF, 1'b0, 8'h00});
    q_hold.push_back(1);
    q_din.push_back('{1'b1, 8'hA5});
    bus_cycle(16'h7FFF, 1'b1, 8'h00, 1, 8'hA5, 3);
    check("sticky_bus_err", 32'(bus_err), 1);

    // Asynchronous reset in the middle of a request
    q_mem.push_back('{21'h00000, 1'b0, 8'h00});
    q_hold.push_back(1);
    q_din.push_back('{1'b0, 8'h00});
    @(posedge clk); #1;
    cpu_addr = 16'h4000; cpu_rw = 1'b1; cpu_dout = 8'h00; e_clk = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    RST = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 0);
    check("arst_cpu_hold", 32'(cpu_hold), 0);
    check("arst_bus_err", 32'(bus_err), 0);
    check("arst_ctrl_q", 32'(ctrl_q), 32'h0505);
    e_clk = 1'b0;
    @(negedge clk); RST = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("q_mem_left", 32'(q_mem.size()), 0);
    check("q_hold_left", 32'(q_hold.size()), 0);
    check("q_din_left", 32'(q_din.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
